fma_add_pipe: RTL and testbench
===============================

// Module: fma_add_pipe
// PURPOSE
//  Parametrised, 3-stage pipelined IEEE-754 adder for the fma16 datapath (half precision by default).
//  Computes x + z with full subnormal, zero, Inf and NaN handling, plus RNE/RZ rounding and exception flags.
//  Uses a valid/ready handshake so it sits between the multiplier stage and the result writeback.
// PARAMETERS
//  NE  5   exponent width (bias = 2^(NE-1)-1)
//  NF  10  stored fraction width; operand width W = 1+NE+NF
// PORTS
//  clk        in   1  rising-edge clock
//  reset_n    in   1  synchronous, active-low reset
//  in_valid   in   1  operands valid
//  in_ready   out  1  block can accept operands this cycle
//  x          in   W  addend A
//  z          in   W  addend B
//  rm         in   1  rounding mode: 0=RNE, 1=RZ (captured with operands)
//  out_valid  out  1  result valid
//  out_ready  in   1  consumer accepts result
//  sum        out  W  rounded result
//  flags      out  3  {invalid, overflow, inexact}
// BEHAVIOUR
//  - Reset (reset_n=0 at a clock edge): all stage valid bits, out_valid, sum and flags go to 0. In-flight ops are discarded.
//  - Handshake: advance = ~out_valid | out_ready; in_ready = advance.
//    A transfer occurs when in_valid & in_ready. The whole pipe stalls as one unit when advance=0.
//    While stalled, sum and flags hold stable.
//  - Latency: exactly 3 cycles from accepted input to out_valid when never stalled. Throughput is 1 op/cycle.
//  - S1 unpack/align:
//    - A subnormal has implicit bit 0 and effective exponent 1.
//    - Swap so that |big| >= |small|, compared on {exp,frac}.
//    - Shift the small significand right by the exponent difference, clamped to NF+4.
//    - Keep guard, round and sticky bits (sticky = OR of all shifted-out bits).
//  - S2 add/LZC:
//    - Effective subtract when the signs differ.
//    - The NF+5-bit significand sum must not go negative; the swap guarantees this.
//    - A leading-zero count is computed on the sum.
//  - S3 normalise/round:
//    - Carry out: shift right 1, exp+1, and fold the dropped bit into sticky.
//    - Otherwise shift left by min(LZC, exp_big-1). If the result is still unnormalised, it is subnormal with exponent field 0.
//    - RNE: increment when G & (R | S | lsb). RZ: truncate.
//    - A rounding carry renormalises, and may promote a subnormal to a normal.
//  - Sign: the sign of the larger-magnitude operand.
//    - An exact-zero result of an effective subtract gives +0 (both modes).
//    - -0 + -0 = -0.
//  - Specials, resolved in S1 and carried down the pipe:
//    - Any NaN input, or +Inf + -Inf: result is canonical qNaN {0,all-ones exp,1,0...}.
//      invalid=1 only for Inf-Inf or a signalling NaN input (frac MSB=0).
//    - Inf + finite: that Inf, no flags.
//  - Overflow: rounded exp reaches all-ones.
//    - RNE gives ±Inf; RZ gives ±max-finite.
//    - overflow=1 and inexact=1 in both modes.
//  - inexact = G|R|S nonzero after the final shift. flags=0 whenever out_valid=0.
//  - Widths: all internal arithmetic uses NF+5 significand bits and NE+2 signed exponent bits; no truncation is permitted before rounding.
// TESTING
//  1. 0x3C00 + 0x4000, RNE -> 0x4200, flags 000, out_valid exactly 3 cycles after accept.
//  2. 0x3C00 + 0xBC00 -> 0x0000 (+0); 0x8000 + 0x8000 -> 0x8000; flags 000.
//  3. 0x6800 + 0x4200: RNE -> 0x6802; RZ -> 0x6801; inexact=1 in both.
//  4. 0x7BFF + 0x7BFF: RNE -> 0x7C00; RZ -> 0x7BFF; flags 011.
//     0x0001 + 0x0001 -> 0x0002, flags 000.
//  5. 0x7C00 + 0xFC00 -> 0x7E00 with flags 100. 0x7D00 + 0x3C00 -> 0x7E00 with flags 100.
//  6. Back-to-back stream of 8 ops with out_ready toggled randomly: no loss or duplication, order preserved.
//     Drop reset_n mid-stream: out_valid=0 on the next cycle and no stale result appears afterwards.

Source files
------------

// File: rtl/fma_add_pipe.sv
// -----------------------------------------------------------------------------
// fma_add_pipe
//   Three-stage pipelined IEEE-754 adder (half precision by default) used in
//   the fma16 datapath between the multiplier stage and result writeback.
//   Computes x + z with subnormal, zero, Inf and NaN handling, RNE/RZ
//   rounding and exception flags.
//
//   Stage 1 unpacks the operands, orders them by magnitude, aligns the small
//   significand and resolves special operands.
//   Stage 2 adds or subtracts the significands and counts leading zeros.
//   Stage 3 normalises, rounds and packs the result into the output register.
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   in_valid   operands valid
//   in_ready   block accepts operands this cycle
//   x, z       addends (W = 1+NE+NF bits)
//   rm         rounding mode, 0 = RNE, 1 = RZ, captured with the operands
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   sum        rounded result
//   flags      {invalid, overflow, inexact}, zero whenever out_valid is 0
// -----------------------------------------------------------------------------
module fma_add_pipe #(
    parameter int NE = 5,
    parameter int NF = 10
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [NE+NF:0] x,
    input  logic [NE+NF:0] z,
    input  logic           rm,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [NE+NF:0] sum,
    output logic [2:0]     flags
);
    localparam int W  = 1 + NE + NF;
    localparam int MW = NF + 4;              // aligned significand {hidden, frac, G, R, S}
    localparam int SW = NF + 5;              // significand sum including carry-out
    localparam int XW = NE + 2;              // internal exponent width
    localparam int LW = $clog2(MW + 1);      // leading-zero count width

    localparam logic [NE-1:0] EXP_ONES = '1;
    localparam logic [NE-1:0] EXP_MAXF = EXP_ONES - 1'b1;
    localparam logic [XW-1:0] EMAX     = {2'b00, EXP_ONES};
    localparam logic [NF-1:0] QFRAC    = {1'b1, {(NF-1){1'b0}}};
    localparam logic [W-1:0]  QNAN     = {1'b0, EXP_ONES, QFRAC};

    // The whole pipe moves as one unit; it only stalls when a finished
    // result is waiting and the consumer refuses it.
    logic w_advance;
    assign w_advance = ~out_valid | out_ready;
    assign in_ready  = w_advance;

    // ---------------------------------------------------------------- S1
    logic          w_sx, w_sz;
    logic [NE-1:0] w_ex, w_ez;
    logic [NF-1:0] w_fx, w_fz;
    assign {w_sx, w_ex, w_fx} = x;
    assign {w_sz, w_ez, w_fz} = z;

    logic w_inf_x, w_inf_z, w_nan_x, w_nan_z, w_snan_x, w_snan_z;
    assign w_inf_x  = (w_ex == EXP_ONES) && (w_fx == '0);
    assign w_inf_z  = (w_ez == EXP_ONES) && (w_fz == '0);
    assign w_nan_x  = (w_ex == EXP_ONES) && (w_fx != '0);
    assign w_nan_z  = (w_ez == EXP_ONES) && (w_fz != '0);
    assign w_snan_x = w_nan_x && !w_fx[NF-1];
    assign w_snan_z = w_nan_z && !w_fz[NF-1];

    // Magnitude order on the raw {exp, frac} field; ties keep x as big.
    logic          w_swap, w_sb;
    logic [NE-1:0] w_eb, w_es, w_eb_eff, w_es_eff;
    logic [NF-1:0] w_fb, w_fs;
    assign w_swap = {w_ez, w_fz} > {w_ex, w_fx};
    assign w_sb   = w_swap ? w_sz : w_sx;
    assign w_eb   = w_swap ? w_ez : w_ex;
    assign w_fb   = w_swap ? w_fz : w_fx;
    assign w_es   = w_swap ? w_ex : w_ez;
    assign w_fs   = w_swap ? w_fx : w_fz;

    // Subnormals use effective exponent 1 with a zero implicit bit.
    assign w_eb_eff = (w_eb == '0) ? NE'(1) : w_eb;
    assign w_es_eff = (w_es == '0) ? NE'(1) : w_es;

    logic [XW-1:0] w_diff, w_shamt;
    assign w_diff  = {2'b00, w_eb_eff} - {2'b00, w_es_eff};
    assign w_shamt = (w_diff > XW'(MW)) ? XW'(MW) : w_diff;

    // Shift through a double-width window so every dropped bit lands in the
    // lower half and can be ORed into sticky.
    logic [2*MW-1:0] w_wide;
    logic [MW-1:0]   w_big, w_small;
    assign w_wide  = {(w_es != '0), w_fs, 3'b000, {MW{1'b0}}} >> w_shamt;
    assign w_small = {w_wide[2*MW-1:MW+1], w_wide[MW] | (|w_wide[MW-1:0])};
    assign w_big   = {(w_eb != '0), w_fb, 3'b000};

    logic         w_special, w_spec_inv;
    logic [W-1:0] w_spec_val;
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an unassigned path infers a latch.
        w_special  = 1'b0;
        w_spec_inv = 1'b0;
        w_spec_val = '0;
        if (w_nan_x || w_nan_z || (w_inf_x && w_inf_z && (w_sx != w_sz))) begin
            w_special  = 1'b1;
            w_spec_val = QNAN;
            w_spec_inv = w_snan_x || w_snan_z || (w_inf_x && w_inf_z);
        end else if (w_inf_x) begin
            w_special  = 1'b1;
            w_spec_val = x;
        end else if (w_inf_z) begin
            w_special  = 1'b1;
            w_spec_val = z;
        end
    end

    logic          r1_valid, r1_rm, r1_sign, r1_sub, r1_special, r1_spec_inv;
    logic [XW-1:0] r1_exp;
    logic [MW-1:0] r1_big, r1_small;
    logic [W-1:0]  r1_spec_val;

    // ---------------------------------------------------------------- S2
    logic [SW-1:0] w_sum2;
    logic [LW-1:0] w_lzc;
    assign w_sum2 = r1_sub ? ({1'b0, r1_big} - {1'b0, r1_small})
                           : ({1'b0, r1_big} + {1'b0, r1_small});

    // Leading zeros below the carry bit; the highest set bit wins.
    always_comb begin
        w_lzc = LW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (w_sum2[i]) w_lzc = LW'(MW - 1 - i);
        end
    end

    logic          r2_valid, r2_rm, r2_sign, r2_sub, r2_special, r2_spec_inv;
    logic [XW-1:0] r2_exp;
    logic [SW-1:0] r2_sum;
    logic [LW-1:0] r2_lzc;
    logic [W-1:0]  r2_spec_val;

    // ---------------------------------------------------------------- S3
    logic [MW-1:0] w_norm;
    logic [XW-1:0] w_lshift, w_exp_n, w_exp_r;
    logic [NF+1:0] w_rnd;
    logic          w_inc, w_inexact, w_ovf, w_sign3;
    logic [NE-1:0] w_field;
    logic [NF-1:0] w_frac;
    logic [W-1:0]  w_res;
    logic [2:0]    w_flags;

    always_comb begin
        w_lshift = '0;
        w_norm   = r2_sum[MW-1:0];
        w_exp_n  = r2_exp;
        if (r2_sum[SW-1]) begin
            // Carry out: drop one bit into sticky and bump the exponent.
            w_norm  = {r2_sum[SW-1:2], r2_sum[1] | r2_sum[0]};
            w_exp_n = r2_exp + 1'b1;
        end else begin
            // Never normalise below exponent 1; what is left is subnormal.
            w_lshift = (XW'(r2_lzc) < (r2_exp - 1'b1)) ? XW'(r2_lzc) : (r2_exp - 1'b1);
            w_norm   = r2_sum[MW-1:0] << w_lshift;
            w_exp_n  = r2_exp - w_lshift;
        end

        w_inexact = |w_norm[2:0];
        w_inc     = !r2_rm && w_norm[2] && (w_norm[1] || w_norm[0] || w_norm[3]);
        w_rnd     = {1'b0, w_norm[MW-1:3]} + {{(NF+1){1'b0}}, w_inc};

        if (w_rnd[NF+1]) begin
            w_exp_r = w_exp_n + 1'b1;
            w_field = w_exp_r[NE-1:0];
            w_frac  = w_rnd[NF:1];
        end else begin
            // A subnormal that rounds up into the hidden bit becomes exponent 1.
            w_exp_r = w_exp_n;
            w_field = w_rnd[NF] ? w_exp_r[NE-1:0] : '0;
            w_frac  = w_rnd[NF-1:0];
        end
        w_ovf = (w_exp_r >= EMAX);

        // Exact cancellation always yields +0, in both rounding modes.
        w_sign3 = (r2_sub && (r2_sum == '0)) ? 1'b0 : r2_sign;

        if (r2_special) begin
            w_res   = r2_spec_val;
            w_flags = {r2_spec_inv, 2'b00};
        end else if (w_ovf) begin
            w_res   = r2_rm ? {r2_sign, EXP_MAXF, {NF{1'b1}}} : {r2_sign, EXP_ONES, {NF{1'b0}}};
            w_flags = 3'b011;
        end else begin
            w_res   = {w_sign3, w_field, w_frac};
            w_flags = {2'b00, w_inexact};
        end
    end

    // ------------------------------------------------------ control registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!reset_n) begin
            r1_valid  <= 1'b0;
            r2_valid  <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            flags     <= '0;
        end else if (w_advance) begin
            r1_valid  <= in_valid;
            r2_valid  <= r1_valid;
            out_valid <= r2_valid;
            sum       <= r2_valid ? w_res : '0;
            flags     <= r2_valid ? w_flags : 3'b000;
        end
    end

    // ------------------------------------------------------- datapath registers
    // NOTE: payload registers carry no reset; they are only observed behind a
    // valid bit, which is reset above.
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r1_rm       <= rm;
            r1_sign     <= w_sb;
            r1_sub      <= w_sx ^ w_sz;
            r1_exp      <= {2'b00, w_eb_eff};
            r1_big      <= w_big;
            r1_small    <= w_small;
            r1_special  <= w_special;
            r1_spec_inv <= w_spec_inv;
            r1_spec_val <= w_spec_val;

            r2_rm       <= r1_rm;
            r2_sign     <= r1_sign;
            r2_sub      <= r1_sub;
            r2_exp      <= r1_exp;
            r2_sum      <= w_sum2;
            r2_lzc      <= w_lzc;
            r2_special  <= r1_special;
            r2_spec_inv <= r1_spec_inv;
            r2_spec_val <= r1_spec_val;
        end
    end

endmodule

// File: tb/tb_fma_add_pipe.sv
// -----------------------------------------------------------------------------
// tb_fma_add_pipe
//   Directed vectors for the half-precision pipelined adder: latency, stall
//   hold, a table of arithmetic and special cases, a randomly back-pressured
//   stream and a mid-stream reset.
// -----------------------------------------------------------------------------
module tb_fma_add_pipe;
    logic        clk = 1'b0;
    logic        reset_n, in_valid, in_ready, rm, out_valid, out_ready;
    logic [15:0] x, z, sum;
    logic [2:0]  flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fma_add_pipe #(.NE(5), .NF(10)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .z         (z),
        .rm        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .flags     (flags)
    );

    typedef struct {
        logic [15:0] vx;
        logic [15:0] vz;
        logic        vrm;
        logic [15:0] vs;
        logic [2:0]  vf;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int i);
        x  = vecs[i].vx;
        z  = vecs[i].vz;
        rm = vecs[i].vrm;
    endtask

    task automatic run_vec(input int i);
        drive(i);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 8 && !out_valid; c++) begin
            @(posedge clk); #1;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL vec%0d timeout: out_valid=0 expected 1", i);
        end else begin
            check($sformatf("vec%0d sum", i), sum, vecs[i].vs);
            check($sformatf("vec%0d flags", i), {13'b0, flags}, {13'b0, vecs[i].vf});
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sent, recv, saw;

        vecs[0]  = '{16'h3C00, 16'h4000, 1'b0, 16'h4200, 3'b000};
        vecs[1]  = '{16'h3C00, 16'hBC00, 1'b0, 16'h0000, 3'b000};
        vecs[2]  = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 3'b000};
        vecs[3]  = '{16'h6800, 16'h4200, 1'b0, 16'h6802, 3'b001};
        vecs[4]  = '{16'h6800, 16'h4200, 1'b1, 16'h6801, 3'b001};
        vecs[5]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b011};
        vecs[6]  = '{16'h7BFF, 16'h7BFF, 1'b1, 16'h7BFF, 3'b011};
        vecs[7]  = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 3'b000};
        vecs[8]  = '{16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 3'b100};
        vecs[9]  = '{16'h7D00, 16'h3C00, 1'b0, 16'h7E00, 3'b100};
        vecs[10] = '{16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 3'b000};
        vecs[11] = '{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 3'b000};
        vecs[12] = '{16'h3C00, 16'hFC00, 1'b0, 16'hFC00, 3'b000};
        vecs[13] = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000};
        vecs[14] = '{16'h3C00, 16'h0001, 1'b0, 16'h3C00, 3'b001};
        vecs[15] = '{16'h4000, 16'hBC00, 1'b0, 16'h3C00, 3'b000};
        vecs[16] = '{16'h0400, 16'h8001, 1'b0, 16'h03FF, 3'b000};
        vecs[17] = '{16'h03FF, 16'h0001, 1'b0, 16'h0400, 3'b000};
        vecs[18] = '{16'h3C01, 16'hBC00, 1'b0, 16'h1400, 3'b000};
        vecs[19] = '{16'hC000, 16'h3C00, 1'b0, 16'hBC00, 3'b000};
        vecs[20] = '{16'hE800, 16'hC200, 1'b1, 16'hE801, 3'b001};
        vecs[21] = '{16'h3C00, 16'hBC00, 1'b1, 16'h0000, 3'b000};
        vecs[22] = '{16'h0000, 16'h8000, 1'b0, 16'h0000, 3'b000};

        // Reset state.
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x = '0; z = '0; rm = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", {15'b0, out_valid}, 16'h0000);
        check("reset sum", sum, 16'h0000);
        check("reset flags", {13'b0, flags}, 16'h0000);
        reset_n = 1'b1;

        // Latency: accepted in cycle 0, result visible in cycle 3.
        drive(0);
        in_valid = 1'b1;
        check("lat in_ready", {15'b0, in_ready}, 16'h0001);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat cycle1 out_valid", {15'b0, out_valid}, 16'h0000);
        @(posedge clk); #1;
        check("lat cycle2 out_valid", {15'b0, out_valid}, 16'h0000);
        @(posedge clk); #1;
        check("lat cycle3 out_valid", {15'b0, out_valid}, 16'h0001);
        check("lat sum", sum, 16'h4200);
        check("lat flags", {13'b0, flags}, 16'h0000);

        // Stall: result must hold while the consumer refuses it.
        out_ready = 1'b0;
        #1;
        check("stall in_ready", {15'b0, in_ready}, 16'h0000);
        @(posedge clk); #1;
        check("stall out_valid", {15'b0, out_valid}, 16'h0001);
        check("stall sum", sum, 16'h4200);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("drain out_valid", {15'b0, out_valid}, 16'h0000);
        check("drain flags", {13'b0, flags}, 16'h0000);

        // Table of single operations.
        for (int i = 0; i < NV; i++) run_vec(i);

        // Back-to-back stream with random back-pressure.
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 300 && recv < 8; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 8);
            if (sent < 8) drive(sent);
            #1;
            if (out_valid && out_ready) begin
                check($sformatf("stream%0d sum", recv), sum, vecs[recv].vs);
                check($sformatf("stream%0d flags", recv), {13'b0, flags}, {13'b0, vecs[recv].vf});
                recv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream count", 16'(recv), 16'd8);
        repeat (4) @(posedge clk);
        #1;
        check("stream no extra", {15'b0, out_valid}, 16'h0000);

        // Reset in the middle of a stream discards everything in flight.
        for (int k = 0; k < 3; k++) begin
            drive(k + 3);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("pre-reset out_valid", {15'b0, out_valid}, 16'h0001);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midreset out_valid", {15'b0, out_valid}, 16'h0000);
        check("midreset flags", {13'b0, flags}, 16'h0000);
        reset_n = 1'b1;
        saw = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid) saw = 1;
        end
        check("no stale result", 16'(saw), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
